// File: rtl/pipeline_debug_ctrl.sv
// Debug/run controller: RUN/HALT/STEP pipe enable, step sync,
// PC breakpoints, saturating cycle counter and read-back mux.
module pipeline_debug_ctrl #(
  parameter int NUM_CH      = 32,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int NUM_BP      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     debug_en,
  input  logic                     debug_step,
  input  logic                     run_cont,
  input  logic [DATA_W-1:0]        pc,
  input  logic                     bp_wr,
  input  logic [2:0]               bp_idx,
  input  logic [DATA_W-1:0]        bp_addr_in,
  input  logic                     bp_valid_in,
  input  logic [ADDR_W-1:0]        debug_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     pipe_en,
  output logic                     halted,
  output logic                     bp_hit,
  output logic [DATA_W-1:0]        debug_data
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t                   state;
  logic                     cause;
  logic                     skip;
  logic [2:0]               lastBp;
  logic [NUM_BP-1:0]        bpValid;
  logic [DATA_W-1:0]        bpAddr [NUM_BP];
  logic [SYNC_STAGES-1:0]   syncQ;
  logic                     hist;
  logic                     stepEdge;
  logic                     bpMatch;
  logic [2:0]               hitIdx;
  logic [DATA_W-1:0]        cycleCnt;
  logic [DATA_W-1:0]        status;
  logic [DATA_W-1:0]        rdData;
  logic [31:0]              addrW;

  assign stepEdge = syncQ[SYNC_STAGES-1] & ~hist;
  assign addrW    = 32'(debug_addr);

  // Breakpoint compare; the lowest matching slot wins.
  always_comb begin
    bpMatch = 1'b0;
    hitIdx  = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bpValid[i] && pc == bpAddr[i]) begin
        bpMatch = 1'b1;
        hitIdx  = 3'(i);
      end
    end
  end

  assign bp_hit  = (state == RUN) && !debug_en
                && bpMatch && !skip;
  assign pipe_en = ((state == RUN) && !debug_en
                && !(bpMatch && !skip))
                || (state == STEP);
  assign halted  = (state != RUN);

  // Step button synchroniser plus history flop for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncQ <= '0;
      hist  <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], debug_step};
      hist  <= syncQ[SYNC_STAGES-1];
    end
  end

  // Run/halt/step state machine.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      cause  <= 1'b0;
      skip   <= 1'b0;
      lastBp <= '0;
    end else begin
      unique case (state)
        RUN: begin
          skip <= 1'b0;
          if (debug_en) begin
            state <= HALT;
            cause <= 1'b0;
          end else if (bpMatch && !skip) begin
            state  <= HALT;
            cause  <= 1'b1;
            lastBp <= hitIdx;
          end
        end
        HALT: begin
          if (stepEdge) begin
            state <= STEP;
          end else if (!debug_en
                    && (!cause || run_cont)) begin
            state <= RUN;
            skip  <= 1'b1;
          end
        end
        STEP:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  // Breakpoint slot writes; out-of-range slots are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bpValid <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bpAddr[i] <= '0;
      end
    end else if (bp_wr) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (32'(bp_idx) == 32'(i)) begin
          bpValid[i] <= bp_valid_in;
          bpAddr[i]  <= bp_addr_in;
        end
      end
    end
  end

  // Count enabled pipeline cycles, holding at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycleCnt <= '0;
    end else if (pipe_en && cycleCnt != '1) begin
      cycleCnt <= cycleCnt + DATA_W'(1);
    end
  end

  // Read-back source select.
  always_comb begin
    status        = '0;
    status[1:0]   = state;
    status[2]     = cause;
    status[3]     = skip;
    status[10:8]  = lastBp;
    rdData        = '1;
    unique case (1'b1)
      (addrW < NUM_CH): begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (addrW == 32'(i)) begin
            rdData = ch_data[i*DATA_W +: DATA_W];
          end
        end
      end
      (addrW == NUM_CH):     rdData = status;
      (addrW == NUM_CH + 1): rdData = cycleCnt;
      (addrW >= NUM_CH + 2
        && addrW < NUM_CH + 2 + NUM_BP): begin
        for (int i = 0; i < NUM_BP; i++) begin
          if (addrW == 32'(NUM_CH + 2 + i)) begin
            rdData = bpAddr[i];
          end
        end
      end
      default: rdData = '1;
    endcase
  end

  // Registered read-back output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      debug_data <= '0;
    end else begin
      debug_data <= rdData;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl: vector table,
// directed corner sequences and random stimulus vs a model.
module tb_pipeline_debug_ctrl;
  localparam int NCH = 32;
  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int NBP = 2;
  localparam int SYN = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, debug_en, debug_step, run_cont;
  logic [DW-1:0]     pc, bp_addr_in;
  logic              bp_wr, bp_valid_in;
  logic [2:0]        bp_idx;
  logic [AW-1:0]     debug_addr;
  logic [NCH*DW-1:0] ch_data;
  logic              pipe_en, halted, bp_hit;
  logic [DW-1:0]     debug_data;

  pipeline_debug_ctrl #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW),
    .NUM_BP(NBP), .SYNC_STAGES(SYN)
  ) dut (
    .clock(clock), .reset(reset),
    .debug_en(debug_en), .debug_step(debug_step),
    .run_cont(run_cont), .pc(pc),
    .bp_wr(bp_wr), .bp_idx(bp_idx),
    .bp_addr_in(bp_addr_in), .bp_valid_in(bp_valid_in),
    .debug_addr(debug_addr), .ch_data(ch_data),
    .pipe_en(pipe_en), .halted(halted),
    .bp_hit(bp_hit), .debug_data(debug_data)
  );

  logic        satRst;
  logic        satPe, satHalt, satHit;
  logic [11:0] satData;
  int          satEdges = 0;

  pipeline_debug_ctrl #(
    .NUM_CH(2), .DATA_W(12), .ADDR_W(3),
    .NUM_BP(1), .SYNC_STAGES(2)
  ) sat (
    .clock(clock), .reset(satRst),
    .debug_en(1'b0), .debug_step(1'b0),
    .run_cont(1'b0), .pc(12'h0),
    .bp_wr(1'b0), .bp_idx(3'd0),
    .bp_addr_in(12'h0), .bp_valid_in(1'b0),
    .debug_addr(3'd3), .ch_data(24'h0),
    .pipe_en(satPe), .halted(satHalt),
    .bp_hit(satHit), .debug_data(satData)
  );

  always @(posedge clock) if (satRst) satEdges <= satEdges + 1;

  int nChecks = 0;
  int nFail   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0=run 1=halt 2=step
  int          mSt;
  bit          mCause, mSkip;
  logic [2:0]  mLast;
  bit          mBpV [NBP];
  logic [31:0] mBpA [NBP];
  bit          stepS[$];
  logic [31:0] mCnt, mData;

  task automatic mReset();
    mSt = 0; mCause = 0; mSkip = 0; mLast = 0;
    for (int i = 0; i < NBP; i++) begin
      mBpV[i] = 0; mBpA[i] = 0;
    end
    stepS.delete();
    mCnt = 0; mData = 0;
  endtask

  function automatic int firstHit();
    for (int i = 0; i < NBP; i++)
      if (mBpV[i] && pc == mBpA[i]) return i;
    return -1;
  endfunction

  function automatic bit mEdge();
    int n = stepS.size();
    bit now  = (n >= SYN)     ? stepS[n-SYN]   : 1'b0;
    bit prev = (n >= SYN + 1) ? stepS[n-SYN-1] : 1'b0;
    return now && !prev;
  endfunction

  function automatic bit mPe();
    int h = firstHit();
    if (mSt == 2) return 1;
    return mSt == 0 && !debug_en && !(h >= 0 && !mSkip);
  endfunction

  function automatic logic [31:0] mRead();
    int a = int'(debug_addr);
    logic [31:0] s = 0;
    if (a < NCH) return ch_data[a*DW +: DW];
    if (a == NCH) begin
      s[1:0]  = mSt[1:0];
      s[2]    = mCause;
      s[3]    = mSkip;
      s[10:8] = mLast;
      return s;
    end
    if (a == NCH + 1) return mCnt;
    if (a >= NCH + 2 && a < NCH + 2 + NBP)
      return mBpA[a-NCH-2];
    return 32'hFFFFFFFF;
  endfunction

  task automatic mClock();
    int h  = firstHit();
    bit e  = mEdge();
    bit pe = mPe();
    mData = mRead();
    if (mSt == 0) begin
      if (debug_en) begin
        mSt = 1; mCause = 0;
      end else if (h >= 0 && !mSkip) begin
        mSt = 1; mCause = 1; mLast = 3'(h);
      end
      mSkip = 0;
    end else if (mSt == 1) begin
      if (e) mSt = 2;
      else if (!debug_en && (!mCause || run_cont)) begin
        mSt = 0; mSkip = 1;
      end
    end else begin
      mSt = 1;
    end
    stepS.push_back(debug_step);
    if (stepS.size() > 8) void'(stepS.pop_front());
    if (pe && mCnt != 32'hFFFFFFFF) mCnt = mCnt + 1;
    if (bp_wr && int'(bp_idx) < NBP) begin
      mBpV[bp_idx] = bp_valid_in;
      mBpA[bp_idx] = bp_addr_in;
    end
  endtask

  bit obsPe, obsHalt, obsHit;

  task automatic runCycle();
    int h;
    if (!reset) mReset();
    #2;
    h = firstHit();
    obsPe = pipe_en; obsHalt = halted; obsHit = bp_hit;
    chk("pipe_en", 32'(pipe_en), 32'(mPe()));
    chk("halted", 32'(halted), 32'(mSt != 0));
    chk("bp_hit", 32'(bp_hit),
        32'(mSt == 0 && !debug_en && h >= 0 && !mSkip));
    @(posedge clock);
    if (reset) mClock();
    else mReset();
    #1;
    chk("debug_data", debug_data, mData);
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  idx;
    logic [31:0] wa;
    bit          wv;
    logic [6:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];
  int   peCnt, pePos, hits, guard;
  logic [31:0] hitPc;
  bit   hitPe;

  initial begin
    tbl[0] = '{0, 3'd0, 32'h0,        0, 7'd5,   32'hDEADBEEF};
    tbl[1] = '{0, 3'd0, 32'h0,        0, 7'd34,  32'h00000010};
    tbl[2] = '{0, 3'd0, 32'h0,        0, 7'd100, 32'hFFFFFFFF};
    tbl[3] = '{1, 3'd5, 32'h12345678, 1, 7'd35,  32'h00000000};
    tbl[4] = '{0, 3'd0, 32'h0,        0, 7'd35,  32'h00000000};
    tbl[5] = '{1, 3'd1, 32'hCAFE0000, 0, 7'd35,  32'h00000000};
    tbl[6] = '{0, 3'd0, 32'h0,        0, 7'd35,  32'hCAFE0000};
    tbl[7] = '{0, 3'd0, 32'h0,        0, 7'd36,  32'hFFFFFFFF};
    tbl[8] = '{0, 3'd0, 32'h0,        0, 7'd31,  32'h31313131};
    tbl[9] = '{0, 3'd0, 32'h0,        0, 7'd0,   32'hA0A0A0A0};

    reset = 0; satRst = 0; debug_en = 0; debug_step = 0;
    run_cont = 0; pc = 0; bp_wr = 0; bp_idx = 0;
    bp_addr_in = 0; bp_valid_in = 0; debug_addr = 0;
    ch_data = '0;
    mReset();
    repeat (3) runCycle();
    chk("rst_data", debug_data, 0);
    chk("rst_pe", 32'(pipe_en), 1);
    chk("rst_halted", 32'(halted), 0);

    reset = 1; satRst = 1;
    repeat (10) runCycle();
    debug_addr = 7'd33; runCycle();
    chk("cnt_after10", debug_data, 10);

    debug_addr = 0; debug_en = 1; runCycle();
    chk("halt_pe0", 32'(obsPe), 0);
    debug_addr = 7'd32; runCycle();
    chk("halted_next", 32'(obsHalt), 1);
    chk("status_dbg", debug_data, 32'h1);

    debug_addr = 7'd33; debug_step = 1;
    peCnt = 0; pePos = -1;
    for (int i = 0; i < 20; i++) begin
      runCycle();
      if (obsPe) begin
        peCnt++;
        if (pePos < 0) pePos = i;
      end
    end
    chk("step_count", peCnt, 1);
    chk("step_pos", pePos, 3);
    chk("step_cnt", debug_data, 12);
    debug_step = 0; debug_en = 0;
    repeat (3) runCycle();
    chk("resume", 32'(obsHalt), 0);

    bp_wr = 1; bp_idx = 0; bp_addr_in = 32'h10;
    bp_valid_in = 1; runCycle();
    bp_wr = 0; pc = 0; hits = 0; hitPc = 0; hitPe = 1;
    for (int i = 0; i < 30; i++) begin
      runCycle();
      if (obsHit) begin
        hits++; hitPc = pc; hitPe = obsPe;
        break;
      end
      if (obsPe) pc = pc + 4;
    end
    chk("bp_seen", hits, 1);
    chk("bp_pc", hitPc, 32'h10);
    chk("bp_pe0", 32'(hitPe), 0);
    debug_addr = 7'd32; runCycle();
    chk("bp_pulse_once", 32'(obsHit), 0);
    chk("bp_halt_pe", 32'(obsPe), 0);
    chk("bp_status", debug_data, 32'h5);
    run_cont = 1; runCycle(); run_cont = 0;
    hits = 0;
    for (int i = 0; i < 20 && pc < 32'h20; i++) begin
      runCycle();
      if (obsHalt || obsHit) hits++;
      if (obsPe) pc = pc + 4;
    end
    chk("resume_pc", 32'(pc >= 32'h20), 1);
    chk("no_rehalt", hits, 0);

    ch_data[5*DW +: DW]  = 32'hDEADBEEF;
    ch_data[31*DW +: DW] = 32'h31313131;
    ch_data[0 +: DW]     = 32'hA0A0A0A0;
    for (int i = 0; i < 10; i++) begin
      bp_wr = tbl[i].wr; bp_idx = tbl[i].idx;
      bp_addr_in = tbl[i].wa; bp_valid_in = tbl[i].wv;
      debug_addr = tbl[i].addr;
      runCycle();
      chk($sformatf("tbl%0d", i), debug_data, tbl[i].exp);
    end
    bp_wr = 0;

    pc = 32'h10; runCycle();
    chk("bp2_hit", 32'(obsHit), 1);
    debug_step = 1; runCycle(); runCycle();
    run_cont = 1; runCycle(); run_cont = 0;
    chk("edge_cycle_pe", 32'(obsPe), 0);
    debug_addr = 7'd32; runCycle();
    chk("step_pe", 32'(obsPe), 1);
    chk("step_halted", 32'(obsHalt), 1);
    chk("step_status", debug_data, 32'h6);
    runCycle();
    chk("post_step_pe", 32'(obsPe), 0);
    chk("post_step_status", debug_data, 32'h5);
    repeat (3) runCycle();
    chk("rc_discarded", 32'(obsHalt), 1);

    debug_step = 0; repeat (4) runCycle();
    debug_step = 1; repeat (3) runCycle();
    #2;
    chk("mid_step_pe", 32'(pipe_en), 1);
    reset = 0;
    #1;
    chk("async_halted", 32'(halted), 0);
    chk("async_data", debug_data, 0);
    mReset();
    debug_step = 0;
    runCycle(); runCycle();
    reset = 1; debug_addr = 7'd32; runCycle();
    chk("post_rst_status", debug_data, 32'h0);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 5) == 0) debug_step = ~debug_step;
      debug_en = ($urandom_range(0, 9) == 0);
      run_cont = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       pc = 32'h10;
        1:       pc = 32'h40;
        default: pc = $urandom;
      endcase
      bp_wr = ($urandom_range(0, 7) == 0);
      bp_idx = 3'($urandom_range(0, 7));
      bp_addr_in = $urandom_range(0, 1) ? 32'h10 : 32'h40;
      bp_valid_in = 1'($urandom_range(0, 1));
      debug_addr = $urandom_range(0, 1)
                 ? 7'($urandom_range(30, 37))
                 : 7'($urandom_range(0, 127));
      for (int i = 0; i < NCH; i++)
        ch_data[i*DW +: DW] = $urandom;
      runCycle();
    end

    guard = 0;
    while (satEdges < 4200 && guard < 6000) begin
      @(posedge clock); #1;
      guard++;
    end
    chk("sat_budget", 32'(satEdges >= 4200), 1);
    chk("sat_cnt", 32'(satData), 32'hFFF);
    @(posedge clock); #1;
    chk("sat_hold", 32'(satData), 32'hFFF);
    chk("sat_pe", 32'(satPe), 1);
    chk("sat_halted", 32'(satHalt), 0);
    chk("sat_hit", 32'(satHit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/pipeline_debug_ctrl.md
Name: pipeline_debug_ctrl

Overview:
Parametrised debug/run controller for the pipelined CPU top. It replaces the raw debug_step clock mux with a single-clock enable (pipe_en) driven by a RUN/HALT/STEP state machine. It adds a synchronised single-step edge detector, programmable PC breakpoints and a saturating executed-cycle counter. It also provides a registered, parametrised read-back mux over NUM_CH flattened probe channels plus internal status words.

Parameters:
NUM_CH, 32, number of external probe channels
DATA_W, 32, width of probe channels, pc, breakpoints, counter, debug_data
ADDR_W, 7, width of debug_addr
NUM_BP, 2, number of PC breakpoints (1..8)
SYNC_STAGES, 2, flops in debug_step synchroniser (>=2)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-low reset
debug_en  in  1  halt request, level
debug_step  in  1  asynchronous step button; its rising edge requests one step
run_cont  in  1  resume-from-breakpoint pulse, synchronous
pc  in  DATA_W  current IF-stage PC, compared against breakpoints
bp_wr  in  1  breakpoint write strobe
bp_idx  in  3  breakpoint slot index
bp_addr_in  in  DATA_W  breakpoint address to write
bp_valid_in  in  1  breakpoint slot enable to write
debug_addr  in  ADDR_W  read-back select
ch_data  in  NUM_CH*DATA_W  probe channels; channel i at [i*DATA_W +: DATA_W]
pipe_en  out  1  pipeline clock enable, combinational from state
halted  out  1  1 when state is HALT or STEP
bp_hit  out  1  one-cycle pulse on the cycle a breakpoint halts the core
debug_data  out  DATA_W  registered read-back data

Behaviour:
- Reset (reset=0, async): state=RUN, cause=0, skip=0, all bp_valid=0, all bp_addr=0, sync/edge flops=0, cycle_cnt=0, bp_hit=0, last_bp=0, debug_data=0. halted=0 and pipe_en=1 unless debug_en=1.
- Step edge: debug_step passes through SYNC_STAGES flops plus one history flop. step_edge = sync_out & ~hist. The edge is generated in every state but is consumed only in HALT. An edge in RUN or STEP is dropped. Holding the button high yields exactly one edge.
- bp_match = OR over i of (bp_valid[i] && pc==bp_addr[i]). The lowest matching index wins for last_bp.
- pipe_en = (RUN && !debug_en && !(bp_match && !skip)) || STEP.
- RUN:
  - debug_en=1 -> HALT, cause=0.
  - Otherwise, bp_match && !skip -> HALT, cause=1, bp_hit=1 for that cycle, last_bp latched.
  - pipe_en is 0 in the match cycle, so the PC stays at the breakpoint address.
  - skip clears after the first RUN cycle.
- HALT:
  - step_edge -> STEP. Step has priority; a run_cont in the same cycle is discarded.
  - Else, debug_en=0 && (cause==0 || run_cont) -> RUN with skip=1.
  - Else stay in HALT.
- STEP:
  - Lasts exactly one cycle with pipe_en=1.
  - Breakpoints are ignored.
  - Always returns to HALT; cause is unchanged.
- Breakpoint write: on a clock edge with bp_wr=1 and bp_idx<NUM_BP, writes bp_addr_in and bp_valid_in; effective the next cycle. Writes with bp_idx>=NUM_BP are ignored. Writes are allowed in any state.
- cycle_cnt: +1 on every cycle with pipe_en=1. Saturates at all-ones and does not wrap.
- Read-back mux (registered, 1-cycle latency):
  - addr<NUM_CH -> channel[addr].
  - NUM_CH -> status word:
    - [1:0] state: RUN=00, HALT=01, STEP=10
    - [2] cause
    - [3] skip
    - [10:8] last_bp
    - remaining bits 0
  - NUM_CH+1 -> cycle_cnt.
  - NUM_CH+2+i (i<NUM_BP) -> {bp_addr[i]}.
  - Any other address -> all-ones.
- debug_en asserted during STEP: STEP completes, then HALT.
- Reset mid-operation: immediate return to reset values; no pending step survives.

Test Plan:
- Release reset with debug_en=0, pc constant 0, no breakpoints. Expected: pipe_en=1 every cycle. Reading addr 33 after 10 cycles returns 10 one cycle after the address is applied.
- Raise debug_en. Expected: pipe_en=0 that cycle; halted=1 next cycle; status=0x1. Hold debug_step high for 20 cycles: exactly one pipe_en=1 cycle, 3 cycles after the rising edge (SYNC_STAGES=2); cycle_cnt +1. Drop debug_en: RUN resumes.
- Write bp0=0x00000010 valid, with pc stepping by 4 from 0. Expected: at pc=0x10, pipe_en=0 and bp_hit=1 for one cycle; status=0x5 with last_bp=0. A run_cont pulse returns to RUN, pc advances past 0x10 without re-halt, and cycle_cnt keeps counting.
- Drive ch_data channel 5=0xDEADBEEF, addr=5. Expected: debug_data=0xDEADBEEF next cycle. addr=34 -> 0x00000010. addr=100 -> 0xFFFFFFFF. bp_idx=5 write is ignored (addr 35 unchanged).
- In HALT from a breakpoint, a step_edge and run_cont arrive in the same cycle. Expected: STEP for one cycle, then HALT; run_cont is discarded.
- Assert reset low mid-STEP, asynchronously between edges. Expected: halted=0 and debug_data=0 immediately; status reads 0x0 after release.
